// File: rtl/i2c_target_sync.sv
// I2C target running on one system clock. SCL/SDA pass through a 2-flop
// synchroniser and a stability filter; all bus decoding uses the filtered
// lines. The target holds a register file with an auto-incrementing, wrapping
// pointer, serves combined-format reads, and mirrors committed writes on a
// strobe port.
module i2c_target_sync #(
  parameter logic [6:0] DEV_ADDR  = 7'h42,
  parameter int         REG_AW    = 8,
  parameter int         MEM_DEPTH = 256,
  parameter int         FILT_LEN  = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_out_en,
  output logic              wr_strobe,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK
  } state_t;

  // Input path
  logic [1:0]          scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [FILT_LEN-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic                scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic                scl_prev_q, sda_prev_q;
  logic                scl_rise, scl_fall, start_evt, stop_evt;

  // Protocol state
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [7:0]          shreg_q, shreg_d;
  logic [REG_AW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic                sda_oe_q, sda_oe_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic [REG_AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [7:0]          mem_q [MEM_DEPTH];
  logic                mem_we;
  logic [7:0]          rx_byte, rd_cur, rd_nxt;
  logic                addr_match, reg_in_range;

  // Synchroniser shift and stability filter: a filtered line only moves once
  // FILT_LEN consecutive synchronised samples agree on the new level.
  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_hist_d = FILT_LEN'({scl_hist_q, scl_sync_q[1]});
    sda_hist_d = FILT_LEN'({sda_hist_q, sda_sync_q[1]});
    scl_filt_d = scl_filt_q;
    sda_filt_d = sda_filt_q;
    if (&scl_hist_q)  scl_filt_d = 1'b1;
    if (~|scl_hist_q) scl_filt_d = 1'b0;
    if (&sda_hist_q)  sda_filt_d = 1'b1;
    if (~|sda_hist_q) sda_filt_d = 1'b0;
  end

  // Input-path registers; idle bus level is high, so reset to 1 to avoid a false edge.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_prev_q <= scl_filt_q;
      sda_prev_q <= sda_filt_q;
    end
  end

  assign scl_rise  = scl_filt_q & ~scl_prev_q;
  assign scl_fall  = ~scl_filt_q & scl_prev_q;
  assign start_evt = scl_filt_q & scl_prev_q & ~sda_filt_q & sda_prev_q;
  assign stop_evt  = scl_filt_q & scl_prev_q & sda_filt_q & ~sda_prev_q;

  assign rx_byte      = {shreg_q[6:0], sda_filt_q};
  assign addr_match   = (shreg_q[7:1] == DEV_ADDR);
  assign reg_in_range = (32'(shreg_q) < 32'(MEM_DEPTH));
  assign ptr_inc      = (ptr_q == REG_AW'(MEM_DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  assign rd_cur       = mem_q[MEM_AW'(ptr_q)];
  assign rd_nxt       = mem_q[MEM_AW'(ptr_inc)];

  // Next-state and output decode; START/STOP take priority over SCL-edge work.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    if (start_evt) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b1;
    end else if (stop_evt) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            shreg_d = rx_byte;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == ST_ADDR)     state_d = ST_ADDR_ACK;
              else if (state_q == ST_REG) state_d = ST_REG_ACK;
              else begin
                state_d     = ST_WDATA_ACK;
                mem_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = rx_byte;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              if (addr_match) begin
                sda_oe_d = 1'b0;
                cnt_d    = 4'd1;
              end else begin
                state_d = ST_IDLE;
              end
            end else if (shreg_q[0]) begin
              state_d  = ST_RDATA;
              sda_oe_d = rd_cur[7];
              shreg_d  = {rd_cur[6:0], 1'b0};
              cnt_d    = 4'd1;
            end else begin
              state_d  = ST_REG;
              sda_oe_d = 1'b1;
              cnt_d    = '0;
            end
          end
        end
        ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              if (state_q == ST_WDATA_ACK) begin
                sda_oe_d = 1'b0;
                ptr_d    = ptr_inc;
                cnt_d    = 4'd1;
              end else if (reg_in_range) begin
                sda_oe_d = 1'b0;
                ptr_d    = REG_AW'(shreg_q);
                cnt_d    = 4'd1;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              state_d  = ST_WDATA;
              sda_oe_d = 1'b1;
              cnt_d    = '0;
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = ST_RDATA_ACK;
              sda_oe_d = 1'b1;
              cnt_d    = '0;
            end else begin
              sda_oe_d = shreg_q[7];
              shreg_d  = {shreg_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_filt_q) state_d = ST_IDLE;
            else            cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d  = ST_RDATA;
            ptr_d    = ptr_inc;
            sda_oe_d = rd_nxt[7];
            shreg_d  = {rd_nxt[6:0], 1'b0};
            cnt_d    = 4'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Protocol state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b1;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Register file write port.
  // NOTE: the register file must come out of reset cleared, so it is on the async reset like every other flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[MEM_AW'(ptr_q)] <= rx_byte;
    end
  end

  assign sda_out_en = sda_oe_q;
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
